// File: rtl/div_16_by_8.sv
// div_16_by_8: sequential restoring divider, 2N-bit dividend by N-bit divisor.
// One quotient bit per CALC cycle, MSB first; results held until the next DONE.
// Optional feature macro: DIV_ZERO_DETECT_EN -- short-circuits a zero divisor
// straight to DONE with quotient all ones, remainder = dividend[N-1:0], dbz=1.
module div_16_by_8 #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           dbz
);

    localparam int CW = $clog2(2*N) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(2*N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;

    logic [2*N-1:0] dvd_q;   // dividend, shifted left one bit per step
    logic [N-1:0]   dsr_q;   // captured divisor
    logic [N:0]     rem_q;   // partial remainder
    logic [2*N-1:0] quo_q;   // quotient bits collected so far
    logic [CW-1:0]  cnt_q;   // step counter
    logic           zero_q;  // divide-by-zero bypass for the current operation

    logic           zero_det;
    logic [N:0]     trial;
    logic [N+1:0]   diff;
    logic           no_borrow;
    logic [N:0]     rem_step;
    logic [2*N-1:0] quo_step;

    logic           accept;
    logic           finish;
    logic           finish_zero;

`ifdef DIV_ZERO_DETECT_EN
    assign zero_det = (divisor == '0);
`else
    assign zero_det = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        trial     = {rem_q[N-1:0], dvd_q[2*N-1]};
        diff      = {1'b0, trial} - {2'b00, dsr_q};
        no_borrow = ~diff[N+1];
        rem_step  = no_borrow ? diff[N:0] : trial;
        quo_step  = {quo_q[2*N-2:0], no_borrow};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        finish      = 1'b0;
        finish_zero = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (zero_q) begin
                    finish_zero = 1'b1;
                    state_nxt   = DONE;
                end else if (cnt_q == LAST_STEP) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and iterative datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            dvd_q  <= dividend;
            dsr_q  <= divisor;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            zero_q <= zero_det;
        end else if (state == CALC && !zero_q) begin
            dvd_q <= {dvd_q[2*N-2:0], 1'b0};
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Result registers: loaded on the edge that enters DONE, held otherwise.
    // The final step's result is taken straight from the step logic so the
    // outputs are valid in the same cycle done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (finish) begin
            quotient  <= quo_step;
            remainder <= rem_step[N-1:0];
        end else if (finish_zero) begin
            quotient  <= '1;
            remainder <= dvd_q[N-1:0];
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    // Divide-by-zero flag, updated alongside the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz <= 1'b0;
        end else if (finish) begin
            dbz <= 1'b0;
        end else if (finish_zero) begin
            dbz <= 1'b1;
        end
    end
`else
    assign dbz = 1'b0;
`endif

    // Status outputs decoded from the state register.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_div_16_by_8.sv
// tb_div_16_by_8: directed self-checking bench for div_16_by_8 (N=8).
// Latency is counted in falling edges after the start-sampling edge, the first
// falling edge after that edge being cycle 1.
module tb_div_16_by_8;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           dbz;

    int total;
    int bad;

    div_16_by_8 #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present operands with start for exactly one rising edge.
    task automatic do_start(input logic [2*N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count falling edges until done is seen; 0 means it never came.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #23;
        total++;
        if ({quotient, remainder, busy, done, dbz} !== '0) begin
            bad++;
            $display("FAIL reset_state: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, dbz);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        // dividend, divisor, quotient, remainder
        logic [2*N-1:0] vec_a [3] = '{16'd1000, 16'd65535, 16'd5};
        logic [N-1:0]   vec_b [3] = '{8'd7, 8'd255, 8'd10};
        logic [2*N-1:0] vec_q [3] = '{16'd142, 16'd257, 16'd0};
        logic [N-1:0]   vec_r [3] = '{8'd6, 8'd0, 8'd5};
        for (int i = 0; i < 3; i++) begin
            do_start(vec_a[i], vec_b[i]);
            wait_done(lat);
            total++;
            if (lat !== 17) begin
                bad++;
                $display("FAIL basic_latency[%0d]: got %0d, want 17", i, lat);
            end
            total++;
            if (quotient !== vec_q[i] || remainder !== vec_r[i] || dbz !== 1'b0) begin
                bad++;
                $display("FAIL basic_result[%0d]: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                         i, quotient, remainder, dbz, vec_q[i], vec_r[i]);
            end
            // Results hold into IDLE.
            repeat (3) @(negedge clk);
            total++;
            if (quotient !== vec_q[i] || remainder !== vec_r[i] || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL basic_hold[%0d]: got q=%0d r=%0d busy=%b done=%b, want q=%0d r=%0d busy=0 done=0",
                         i, quotient, remainder, busy, done, vec_q[i], vec_r[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int pulses;
        int busy_low;
        int first_done;
        logic [2*N-1:0] q_seen;
        logic [N-1:0]   r_seen;
        pulses = 0;
        busy_low = 0;
        first_done = 0;
        q_seen = '0;
        r_seen = '0;
        do_start(16'd1000, 8'd7);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c <= 17 && !busy) busy_low++;
            if (done) begin
                pulses++;
                if (first_done == 0) begin
                    first_done = c;
                    q_seen = quotient;
                    r_seen = remainder;
                end
            end
            // Spurious starts at CALC cycles 3 and 9, and one during DONE.
            if (c == 3 || c == 9 || c == 17) begin
                dividend = 16'd4321 + 16'(c);
                divisor  = 8'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        total++;
        if (pulses !== 1 || first_done !== 17) begin
            bad++;
            $display("FAIL ignore_done_pulses: got %0d pulses first at %0d, want 1 at 17", pulses, first_done);
        end
        total++;
        if (q_seen !== 16'd142 || r_seen !== 8'd6) begin
            bad++;
            $display("FAIL ignore_result: got q=%0d r=%0d, want q=142 r=6", q_seen, r_seen);
        end
        total++;
        if (busy_low !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_busy: got %0d low cycles, final busy=%b, want 0 and 0", busy_low, busy);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int pulses;
        do_start(16'd1000, 8'd7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({quotient, remainder, busy, done, dbz} !== '0) begin
            bad++;
            $display("FAIL abort_clear: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, dbz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy || quotient !== '0) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d active cycles, want 0", pulses);
        end
        do_start(16'd200, 8'd9);
        wait_done(lat);
        total++;
        if (lat !== 17 || quotient !== 16'd22 || remainder !== 8'd2) begin
            bad++;
            $display("FAIL abort_restart: got lat=%0d q=%0d r=%0d, want lat=17 q=22 r=2",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        do_start(16'd100, 8'd3);
        wait_done(lat);
        total++;
        if (lat !== 17 || quotient !== 16'd33 || remainder !== 8'd1) begin
            bad++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d, want lat=17 q=33 r=1", lat, quotient, remainder);
        end
        // Next falling edge is in the IDLE cycle right after DONE.
        do_start(16'd255, 8'd16);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b, want 1", busy);
        end
        wait_done(lat);
        total++;
        if (lat !== 17 || quotient !== 16'd15 || remainder !== 8'd15) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d, want lat=17 q=15 r=15", lat, quotient, remainder);
        end
    endtask

    task automatic test_div_zero;
        int lat;
        do_start(16'h1234, 8'd0);
        wait_done(lat);
`ifdef DIV_ZERO_DETECT_EN
        total++;
        if (lat !== 2 || quotient !== 16'hFFFF || remainder !== 8'h34 || dbz !== 1'b1) begin
            bad++;
            $display("FAIL dbz_detect: got lat=%0d q=%h r=%h dbz=%b, want lat=2 q=ffff r=34 dbz=1",
                     lat, quotient, remainder, dbz);
        end
        // A following nonzero divisor clears dbz.
        @(negedge clk);
        do_start(16'd50, 8'd5);
        wait_done(lat);
        total++;
        if (quotient !== 16'd10 || remainder !== 8'd0 || dbz !== 1'b0) begin
            bad++;
            $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b, want q=10 r=0 dbz=0", quotient, remainder, dbz);
        end
`else
        total++;
        if (lat !== 17 || dbz !== 1'b0) begin
            bad++;
            $display("FAIL dbz_off: got lat=%0d dbz=%b, want lat=17 dbz=0", lat, dbz);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_basic;
        test_ignore_start;
        test_reset_abort;
        @(negedge clk);
        test_back_to_back;
        @(negedge clk);
        test_div_zero;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
